chroni_vram_responder: RTL and testbench

- Memory-side responder for the chroni video read port: serves `rd_req`/`addr_out`/`addr_out_page` requests from chroni and returns `data_in` with a one-cycle `rd_ack` pulse.
- Owns the on-chip video RAM.
- Accepts CPU byte writes through a small posted-write FIFO, retired when the video side is idle.
- Sits between chroni, the CPU bus decoder and the VRAM array.

---
 rtl/chroni_vram_responder.sv | 139 +++++++++++++
 tb/tb_chroni_vram_responder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/chroni_vram_responder.sv
`default_nettype none
// ============================================================================
// chroni_vram_responder : video RAM read responder with CPU posted-write FIFO
// Revision 1.0
// ============================================================================
module chroni_vram_responder #(
  parameter int         MEM_AW     = 14,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] OOR_DATA   = 8'h00
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic        rd_req,
  input  logic [12:0] addr_in,
  input  logic [7:0]  addr_in_page,
  output logic [7:0]  data_out,
  output logic        rd_ack,
  input  logic        cpu_wr_en,
  input  logic [20:0] cpu_wr_addr,
  input  logic [7:0]  cpu_wr_data,
  output logic        cpu_wr_full,
  output logic        cpu_wr_ovf,
  output logic        busy
);

  localparam int            C_PW    = $clog2(FIFO_DEPTH);
  localparam int            C_CW    = C_PW + 1;
  localparam logic [C_CW-1:0] C_DEPTH = C_CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_MEM = 2'd1,
    RD_ACK = 2'd2,
    WR     = 2'd3
  } state_t;

  state_t            r_state;
  logic [7:0]        r_mem [2**MEM_AW];
  logic [7:0]        r_rdata;
  logic              r_oor;
  logic [20:0]       r_fifo_addr [FIFO_DEPTH];
  logic [7:0]        r_fifo_data [FIFO_DEPTH];
  logic [C_PW-1:0]   r_wr_ptr;
  logic [C_PW-1:0]   r_rd_ptr;
  logic [C_CW-1:0]   r_count;

  logic [20:0]       w_rd_full;
  logic [20:0]       w_head_addr;
  logic [7:0]        w_head_data;
  logic              w_rd_oor;
  logic              w_head_oor;
  logic              w_push;
  logic              w_pop;
  logic              w_ram_re;
  logic              w_ram_we;
  logic [C_CW-1:0]   w_count_next;

  assign w_rd_full   = {addr_in_page, addr_in};
  assign w_rd_oor    = |w_rd_full[20:MEM_AW];
  assign w_head_addr = r_fifo_addr[r_rd_ptr];
  assign w_head_data = r_fifo_data[r_rd_ptr];
  assign w_head_oor  = |w_head_addr[20:MEM_AW];

  // Full is taken from the registered flag, so a push in the cycle the FIFO fills is still accepted
  assign w_push       = cpu_wr_en & ~cpu_wr_full;
  assign w_pop        = (r_state == WR);
  assign w_count_next = r_count + C_CW'(w_push) - C_CW'(w_pop);

  // Single RAM port: reads only on the IDLE->RD_MEM edge, writes only on the WR->IDLE edge
  assign w_ram_re = (r_state == IDLE) & ~cpu_wr_full & rd_req;
  assign w_ram_we = w_pop & ~w_head_oor;

  assign busy = (r_state != IDLE) | (r_count != '0);

  always_ff @(posedge vga_clk) begin
    if (w_ram_we) begin
      r_mem[w_head_addr[MEM_AW-1:0]] <= w_head_data;
    end
    if (w_ram_re) begin
      r_rdata <= r_mem[w_rd_full[MEM_AW-1:0]];
    end
  end

  always_ff @(posedge vga_clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= cpu_wr_addr;
      r_fifo_data[r_wr_ptr] <= cpu_wr_data;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      rd_ack      <= 1'b0;
      data_out    <= 8'h00;
      r_oor       <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      cpu_wr_full <= 1'b0;
      cpu_wr_ovf  <= 1'b0;
    end else begin
      rd_ack      <= 1'b0;
      cpu_wr_ovf  <= cpu_wr_en & cpu_wr_full;
      r_count     <= w_count_next;
      cpu_wr_full <= (w_count_next == C_DEPTH);
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + C_PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PW'(1);
      end

      case (r_state)
        IDLE: begin
          // A full FIFO wins over video so CPU writes cannot be starved into overflow
          if (cpu_wr_full) begin
            r_state <= WR;
          end else if (rd_req) begin
            r_oor   <= w_rd_oor;
            r_state <= RD_MEM;
          end else if (r_count != '0) begin
            r_state <= WR;
          end
        end
        RD_MEM: begin
          rd_ack   <= 1'b1;
          data_out <= r_oor ? OOR_DATA : r_rdata;
          r_state  <= RD_ACK;
        end
        RD_ACK:  r_state <= IDLE;
        WR:      r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_chroni_vram_responder.sv
`default_nettype none
// tb_chroni_vram_responder : directed self-checking bench for the chroni VRAM responder.
module tb_chroni_vram_responder;

  logic        vga_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rd_req = 1'b0;
  logic [12:0] addr_in = '0;
  logic [7:0]  addr_in_page = '0;
  logic [7:0]  data_out;
  logic        rd_ack;
  logic        cpu_wr_en = 1'b0;
  logic [20:0] cpu_wr_addr = '0;
  logic [7:0]  cpu_wr_data = '0;
  logic        cpu_wr_full;
  logic        cpu_wr_ovf;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 vga_clk = ~vga_clk;

  chroni_vram_responder #(
    .MEM_AW    (14),
    .FIFO_DEPTH(4),
    .OOR_DATA  (8'h00)
  ) dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .rd_req      (rd_req),
    .addr_in     (addr_in),
    .addr_in_page(addr_in_page),
    .data_out    (data_out),
    .rd_ack      (rd_ack),
    .cpu_wr_en   (cpu_wr_en),
    .cpu_wr_addr (cpu_wr_addr),
    .cpu_wr_data (cpu_wr_data),
    .cpu_wr_full (cpu_wr_full),
    .cpu_wr_ovf  (cpu_wr_ovf),
    .busy        (busy)
  );

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  // Returns ack latency in cycles from the request cycle, or -1 on timeout
  task automatic do_read(input logic [20:0] fa, output logic [7:0] d, output int lat);
    bit done;
    done = 1'b0;
    lat = -1;
    d = 8'hxx;
    addr_in_page = fa[20:13];
    addr_in = fa[12:0];
    rd_req = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      if (!done) begin
        tick();
        if (rd_ack) begin
          lat = i;
          d = data_out;
          done = 1'b1;
          rd_req = 1'b0;
        end
      end
    end
    rd_req = 1'b0;
    tick();
  endtask

  task automatic write_byte(input logic [20:0] a, input logic [7:0] d);
    cpu_wr_addr = a;
    cpu_wr_data = d;
    cpu_wr_en = 1'b1;
    tick();
    cpu_wr_en = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      if (n < 0) begin
        tick();
        if (!busy) n = i;
      end
    end
  endtask

  task automatic preload(input logic [20:0] a, input logic [7:0] d);
    int n;
    write_byte(a, d);
    wait_idle(n);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    checks++; if (rd_ack !== 1'b0) begin errors++; $display("FAIL reset_rd_ack: got %b expected 0", rd_ack); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
    checks++; if (cpu_wr_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", cpu_wr_full); end
    checks++; if (cpu_wr_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", cpu_wr_ovf); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    reset_n = 1'b1;
    repeat (2) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single_read();
    logic [7:0] d;
    int lat;
    preload(21'h00401, 8'h41);
    preload(21'h0020A, 8'h3C);
    do_read(21'h00401, d, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL single_latency: got %0d expected 2", lat); end
    checks++; if (d !== 8'h41) begin errors++; $display("FAIL single_data: got %h expected 41", d); end
    checks++; if (rd_ack !== 1'b0) begin errors++; $display("FAIL single_ack_width: got %b expected 0", rd_ack); end
  endtask

  task automatic test_back_to_back();
    int t[2];
    logic [7:0] dv[2];
    int n;
    t[0] = -1; t[1] = -1; dv[0] = 8'hxx; dv[1] = 8'hxx;
    n = 0;
    addr_in_page = 8'h00;
    addr_in = 13'h0401;
    rd_req = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      if (n < 2) begin
        tick();
        if (rd_ack) begin
          t[n] = c;
          dv[n] = data_out;
          n++;
          if (n == 1) addr_in = {8'd65, 3'd2};
          else rd_req = 1'b0;
        end
      end
    end
    rd_req = 1'b0;
    repeat (2) tick();
    checks++; if (dv[0] !== 8'h41) begin errors++; $display("FAIL b2b_data0: got %h expected 41", dv[0]); end
    checks++; if (dv[1] !== 8'h3C) begin errors++; $display("FAIL b2b_data1: got %h expected 3c", dv[1]); end
    checks++; if (t[0] !== 2) begin errors++; $display("FAIL b2b_first_lat: got %0d expected 2", t[0]); end
    checks++; if (t[1] - t[0] !== 3) begin errors++; $display("FAIL b2b_spacing: got %0d expected 3", t[1] - t[0]); end
  endtask

  task automatic test_cpu_write();
    int n;
    logic [7:0] d;
    int lat;
    cpu_wr_en = 1'b1;
    cpu_wr_addr = 21'h00100; cpu_wr_data = 8'hAA;
    tick();
    cpu_wr_addr = 21'h00101; cpu_wr_data = 8'hBB;
    tick();
    cpu_wr_en = 1'b0;
    wait_idle(n);
    checks++; if (n < 1 || n > 4) begin errors++; $display("FAIL wr_commit_cycles: got %0d expected 1..4", n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_idle: got %b expected 0", busy); end
    do_read(21'h00100, d, lat);
    checks++; if (d !== 8'hAA) begin errors++; $display("FAIL wr_read_100: got %h expected aa", d); end
    do_read(21'h00101, d, lat);
    checks++; if (d !== 8'hBB) begin errors++; $display("FAIL wr_read_101: got %h expected bb", d); end
  endtask

  task automatic test_fifo_full();
    int ack_t[3];
    logic [7:0] ack_d[3];
    logic full_obs[15];
    logic ovf_obs[15];
    int na;
    int n;
    logic [7:0] d;
    int lat;
    preload(21'h00304, 8'h77);
    for (int i = 0; i < 3; i++) begin ack_t[i] = -1; ack_d[i] = 8'hxx; end
    na = 0;
    addr_in_page = 8'h00;
    addr_in = 13'h0401;
    rd_req = 1'b1;
    for (int c = 0; c < 15; c++) begin
      cpu_wr_en = (c < 5);
      cpu_wr_addr = 21'h00300 + 21'(c);
      cpu_wr_data = (c == 4) ? 8'h55 : 8'h10 + 8'(c);
      tick();
      full_obs[c] = cpu_wr_full;
      ovf_obs[c] = cpu_wr_ovf;
      if (rd_ack && na < 3) begin
        ack_t[na] = c;
        ack_d[na] = data_out;
        na++;
      end
    end
    cpu_wr_en = 1'b0;
    rd_req = 1'b0;
    wait_idle(n);
    checks++; if (full_obs[2] !== 1'b0) begin errors++; $display("FAIL full_after3: got %b expected 0", full_obs[2]); end
    checks++; if (full_obs[3] !== 1'b1) begin errors++; $display("FAIL full_after4: got %b expected 1", full_obs[3]); end
    checks++; if (ovf_obs[4] !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b expected 1", ovf_obs[4]); end
    checks++; if (ovf_obs[5] !== 1'b0) begin errors++; $display("FAIL ovf_width: got %b expected 0", ovf_obs[5]); end
    checks++; if (full_obs[7] !== 1'b0) begin errors++; $display("FAIL full_after_drain: got %b expected 0", full_obs[7]); end
    checks++; if (ack_t[0] !== 1) begin errors++; $display("FAIL full_ack0_time: got %0d expected 1", ack_t[0]); end
    checks++; if (ack_t[1] !== 4) begin errors++; $display("FAIL full_ack1_time: got %0d expected 4", ack_t[1]); end
    checks++; if (ack_t[2] - ack_t[1] !== 5) begin errors++; $display("FAIL full_ack_gap_one_wr: got %0d expected 5", ack_t[2] - ack_t[1]); end
    checks++; if (ack_d[2] !== 8'h41) begin errors++; $display("FAIL full_ack_data: got %h expected 41", ack_d[2]); end
    checks++; if (n < 0) begin errors++; $display("FAIL full_drain_timeout: got %0d expected >=0", n); end
    for (int i = 0; i < 4; i++) begin
      do_read(21'h00300 + 21'(i), d, lat);
      checks++; if (d !== 8'h10 + 8'(i)) begin errors++; $display("FAIL full_commit_%0d: got %h expected %h", i, d, 8'h10 + 8'(i)); end
    end
    do_read(21'h00304, d, lat);
    checks++; if (d !== 8'h77) begin errors++; $display("FAIL dropped_write: got %h expected 77", d); end
  endtask

  task automatic test_out_of_range();
    logic [7:0] d;
    int lat;
    int n;
    preload(21'h00000, 8'h5A);
    preload(21'h03FFF, 8'h66);
    do_read(21'h04000, d, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL oor_ack_latency: got %0d expected 2", lat); end
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL oor_data: got %h expected 00", d); end
    write_byte(21'h1FFFFF, 8'hEE);
    wait_idle(n);
    checks++; if (n < 0) begin errors++; $display("FAIL oor_write_drain: got %0d expected >=0", n); end
    do_read(21'h03FFF, d, lat);
    checks++; if (d !== 8'h66) begin errors++; $display("FAIL oor_write_alias_top: got %h expected 66", d); end
    do_read(21'h00000, d, lat);
    checks++; if (d !== 8'h5A) begin errors++; $display("FAIL oor_read_alias_zero: got %h expected 5a", d); end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] d;
    int lat;
    int acks;
    acks = 0;
    addr_in_page = 8'h00;
    addr_in = 13'h0401;
    rd_req = 1'b1;
    tick();
    reset_n = 1'b0;
    rd_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rd_ack) acks++;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rd_ack) acks++;
    end
    checks++; if (acks !== 0) begin errors++; $display("FAIL rst_mid_no_ack: got %0d expected 0", acks); end
    do_read(21'h0020A, d, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL rst_after_latency: got %0d expected 2", lat); end
    checks++; if (d !== 8'h3C) begin errors++; $display("FAIL rst_after_data: got %h expected 3c", d); end
    do_read(21'h00401, d, lat);
    checks++; if (d !== 8'h41) begin errors++; $display("FAIL rst_ram_kept: got %h expected 41", d); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_cpu_write();
    test_fifo_full();
    test_out_of_range();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
